// File: rtl/game_flow_pkg.sv
// Shared game-flow definitions: state encodings used by the FSM and the RGB mux,
// plus the ball-speed width and a saturating speed-step helper.
package game_flow_pkg;

    localparam int SPEED_W = 4;

    typedef enum logic [2:0] {
        MENU      = 3'd0,
        GAME_PLAY = 3'd1,
        SETTINGS  = 3'd2,
        COUNTDOWN = 3'd3,
        OVER      = 3'd4,
        PAUSED    = 3'd5
    } game_state_e;

    // Up and down together cancel; each direction saturates at its bound.
    function automatic logic [SPEED_W-1:0] speed_step(
        input logic [SPEED_W-1:0] speed,
        input logic               up,
        input logic               down,
        input logic [SPEED_W-1:0] lo,
        input logic [SPEED_W-1:0] hi
    );
        if (up && !down && speed < hi) return speed + 1'b1;
        if (down && !up && speed > lo) return speed - 1'b1;
        return speed;
    endfunction

endpackage

// File: rtl/frame_sec_counter.sv
// Divides refresh_tick by FRAMES_PER_SEC; sec_tick fires on the wrapping tick.
// clear restarts the count, hold freezes it and suppresses sec_tick.
module frame_sec_counter #(
    parameter int FRAMES_PER_SEC = 60
) (
    input  logic clk,
    input  logic reset,
    input  logic refresh_tick,
    input  logic clear,
    input  logic hold,
    output logic sec_tick
);

    localparam int CNT_W = (FRAMES_PER_SEC > 1) ? $clog2(FRAMES_PER_SEC) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAMES_PER_SEC - 1);

    logic [CNT_W-1:0] frame_cnt;

    assign sec_tick = refresh_tick && !hold && (frame_cnt == LAST);

    // clear wins over a coincident tick, so the entry-cycle tick is not counted
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            frame_cnt <= '0;
        end else if (refresh_tick && !hold) begin
            frame_cnt <= sec_tick ? '0 : frame_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/game_flow_fsm.sv
// Game-flow controller: menu, settings, 3-2-1 countdown, play and timed game-over hold.
// Define GAME_PAUSE_EN to add the PAUSED state (start toggles PLAY/PAUSED).
module game_flow_fsm
    import game_flow_pkg::*;
#(
    parameter int FRAMES_PER_SEC = 60,
    parameter int COUNT_SEC      = 3,
    parameter int OVER_HOLD_SEC  = 5,
    parameter int SPEED_MIN      = 1,
    parameter int SPEED_MAX      = 8,
    parameter int SPEED_DEFAULT  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       refresh_tick,
    input  logic       start_pulse,
    input  logic       setting_pulse,
    input  logic       up_pulse,
    input  logic       down_pulse,
    input  logic       game_over,
    output logic [2:0] game_state,
    output logic       game_active,
    output logic       ball_reset,
    output logic [3:0] ball_speed,
    output logic [1:0] count_val
);

    localparam int SEC_W = (OVER_HOLD_SEC > 1) ? $clog2(OVER_HOLD_SEC) : 1;

    game_state_e        state_r, state_nx;
    logic [1:0]         count_r, count_nx;
    logic [SEC_W-1:0]   sec_cnt_r, sec_cnt_nx;
    logic [SPEED_W-1:0] speed_r, speed_nx;
    logic               active_r, ball_reset_r;
    logic               clear_cnt, hold_cnt, sec_tick, entering_cd;

`ifdef GAME_PAUSE_EN
    assign hold_cnt = (state_r == PAUSED);
`else
    assign hold_cnt = 1'b0;
`endif

    frame_sec_counter #(
        .FRAMES_PER_SEC(FRAMES_PER_SEC)
    ) u_frame_sec_counter (
        .clk         (clk),
        .reset       (reset),
        .refresh_tick(refresh_tick),
        .clear       (clear_cnt),
        .hold        (hold_cnt),
        .sec_tick    (sec_tick)
    );

    always_comb begin
        state_nx   = state_r;
        count_nx   = count_r;
        sec_cnt_nx = sec_cnt_r;
        speed_nx   = speed_r;
        case (state_r)
            MENU: begin
                if (start_pulse)        state_nx = COUNTDOWN;
                else if (setting_pulse) state_nx = SETTINGS;
            end
            SETTINGS: begin
                if (setting_pulse || start_pulse) state_nx = MENU;
                else speed_nx = speed_step(speed_r, up_pulse, down_pulse,
                                           SPEED_W'(SPEED_MIN), SPEED_W'(SPEED_MAX));
            end
            COUNTDOWN: begin
                if (sec_tick) begin
                    if (count_r <= 2'd1) state_nx = GAME_PLAY;
                    else                 count_nx = count_r - 2'd1;
                end
            end
            GAME_PLAY: begin
                if (game_over) state_nx = OVER;
`ifdef GAME_PAUSE_EN
                else if (start_pulse) state_nx = PAUSED;
`endif
            end
            OVER: begin
                if (start_pulse) state_nx = COUNTDOWN;
                else if (sec_tick) begin
                    if (sec_cnt_r == SEC_W'(OVER_HOLD_SEC - 1)) state_nx = MENU;
                    else sec_cnt_nx = sec_cnt_r + 1'b1;
                end
            end
`ifdef GAME_PAUSE_EN
            PAUSED: begin
                if (start_pulse)        state_nx = GAME_PLAY;
                else if (setting_pulse) state_nx = MENU;
            end
`endif
            default: state_nx = MENU;
        endcase

        // Entry actions shared by every path into COUNTDOWN / OVER
        entering_cd = (state_nx == COUNTDOWN) && (state_r != COUNTDOWN);
        if (entering_cd)              count_nx = 2'(COUNT_SEC);
        if (state_nx != COUNTDOWN)    count_nx = 2'd0;
        if (state_nx == OVER && state_r != OVER) sec_cnt_nx = '0;
        clear_cnt = (state_nx != state_r) && (state_nx == COUNTDOWN || state_nx == OVER);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= MENU;
            count_r      <= 2'd0;
            sec_cnt_r    <= '0;
            speed_r      <= SPEED_W'(SPEED_DEFAULT);
            active_r     <= 1'b0;
            ball_reset_r <= 1'b0;
        end else begin
            state_r      <= state_nx;
            count_r      <= count_nx;
            sec_cnt_r    <= sec_cnt_nx;
            speed_r      <= speed_nx;
            active_r     <= (state_nx == GAME_PLAY);
            ball_reset_r <= entering_cd;
        end
    end

    assign game_state  = state_r;
    assign game_active = active_r;
    assign ball_reset  = ball_reset_r;
    assign ball_speed  = speed_r;
    assign count_val   = count_r;

endmodule

// File: tb/tb_game_flow_fsm.sv
// Directed bench for game_flow_fsm with FRAMES_PER_SEC=4: settings table plus
// countdown, game-over hold, rematch and reset sequences.
module tb_game_flow_fsm;
    import game_flow_pkg::*;

    logic       clk = 1'b0;
    logic       reset, refresh_tick, start_pulse, setting_pulse, up_pulse, down_pulse, game_over;
    logic [2:0] game_state;
    logic       game_active, ball_reset;
    logic [3:0] ball_speed;
    logic [1:0] count_val;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic st, se, up, dn;
        int   exp_state;
        int   exp_speed;
    } vec_t;
    vec_t vq[$];

    game_flow_fsm #(.FRAMES_PER_SEC(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .refresh_tick (refresh_tick),
        .start_pulse  (start_pulse),
        .setting_pulse(setting_pulse),
        .up_pulse     (up_pulse),
        .down_pulse   (down_pulse),
        .game_over    (game_over),
        .game_state   (game_state),
        .game_active  (game_active),
        .ball_reset   (ball_reset),
        .ball_speed   (ball_speed),
        .count_val    (count_val)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_out(input string tag, input int st, input int act, input int br,
                              input int spd, input int cnt);
        chk({tag, ".state"}, 32'(game_state), st);
        chk({tag, ".active"}, 32'(game_active), act);
        chk({tag, ".ball_reset"}, 32'(ball_reset), br);
        chk({tag, ".speed"}, 32'(ball_speed), spd);
        chk({tag, ".count"}, 32'(count_val), cnt);
    endtask

    // One clock: drive strobes, take the edge, sample 1 time unit later.
    task automatic step(input logic st, input logic se, input logic up, input logic dn,
                        input logic tk, input logic go);
        start_pulse = st; setting_pulse = se; up_pulse = up; down_pulse = dn;
        refresh_tick = tk; game_over = go;
        @(posedge clk);
        #1;
        start_pulse = 0; setting_pulse = 0; up_pulse = 0; down_pulse = 0; refresh_tick = 0;
    endtask

    task automatic tick(input logic st);
        step(st, 0, 0, 0, 1, 0);
    endtask

    initial begin
        int st, cnt;
        reset = 1; refresh_tick = 0; start_pulse = 0; setting_pulse = 0;
        up_pulse = 0; down_pulse = 0; game_over = 0;
        @(posedge clk); @(posedge clk); #1;
        expect_out("reset", int'(MENU), 0, 0, 3, 0);
        reset = 0;

        // Settings table: {start, setting, up, down, exp_state, exp_speed}
        vq.push_back('{0, 1, 0, 0, int'(SETTINGS), 3});
        for (int i = 4; i <= 8; i++) vq.push_back('{0, 0, 1, 0, int'(SETTINGS), i});
        vq.push_back('{0, 0, 1, 0, int'(SETTINGS), 8});
        vq.push_back('{0, 0, 1, 1, int'(SETTINGS), 8});
        for (int i = 7; i >= 1; i--) vq.push_back('{0, 0, 0, 1, int'(SETTINGS), i});
        vq.push_back('{0, 0, 0, 1, int'(SETTINGS), 1});
        vq.push_back('{0, 0, 0, 1, int'(SETTINGS), 1});
        vq.push_back('{0, 1, 1, 0, int'(MENU), 1});
        vq.push_back('{0, 0, 1, 0, int'(MENU), 1});
        vq.push_back('{0, 1, 0, 0, int'(SETTINGS), 1});
        vq.push_back('{1, 0, 0, 1, int'(MENU), 1});
        foreach (vq[i]) begin
            step(vq[i].st, vq[i].se, vq[i].up, vq[i].dn, 0, 0);
            expect_out($sformatf("vec%0d", i), vq[i].exp_state, 0, 0, vq[i].exp_speed, 0);
        end

        // Start and setting together in MENU: start wins, one-cycle ball_reset
        step(1, 1, 0, 0, 0, 0);
        expect_out("both_start", int'(COUNTDOWN), 0, 1, 1, 3);
        step(0, 0, 0, 0, 0, 0);
        expect_out("cd_idle", int'(COUNTDOWN), 0, 0, 1, 3);

        for (int k = 1; k <= 12; k++) begin
            tick(0);
            cnt = (k < 4) ? 3 : (k < 8) ? 2 : (k < 12) ? 1 : 0;
            st  = (k < 12) ? int'(COUNTDOWN) : int'(GAME_PLAY);
            expect_out($sformatf("cd_tick%0d", k), st, (k == 12) ? 1 : 0, 0, 1, cnt);
        end

`ifdef GAME_PAUSE_EN
        tick(0); tick(0);
        step(1, 0, 0, 0, 0, 0);
        expect_out("pause", int'(PAUSED), 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) step(0, 0, 0, 0, 1, 1);
        expect_out("paused_hold", int'(PAUSED), 0, 0, 1, 0);
        step(1, 0, 0, 0, 0, 1);
        expect_out("resume", int'(GAME_PLAY), 1, 0, 1, 0);
`else
        step(1, 0, 0, 0, 0, 0);
        expect_out("play_start_ignored", int'(GAME_PLAY), 1, 0, 1, 0);
`endif

        step(0, 0, 0, 0, 0, 1);
        expect_out("game_over", int'(OVER), 0, 0, 1, 0);
        game_over = 0;
        for (int k = 1; k <= 20; k++) begin
            tick(0);
            expect_out($sformatf("over_tick%0d", k), (k < 20) ? int'(OVER) : int'(MENU), 0, 0, 1, 0);
        end

        // Rematch: start coinciding with the hold timeout
        step(1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 12; k++) tick(0);
        expect_out("play2", int'(GAME_PLAY), 1, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1);
        game_over = 0;
        for (int k = 0; k < 19; k++) tick(0);
        expect_out("over2_pre", int'(OVER), 0, 0, 1, 0);
        tick(1);
        expect_out("rematch", int'(COUNTDOWN), 0, 1, 1, 3);
        for (int k = 1; k <= 4; k++) begin
            tick(0);
            expect_out($sformatf("cd2_tick%0d", k), int'(COUNTDOWN), 0, 0, 1, (k < 4) ? 3 : 2);
        end

        // Reset in COUNTDOWN
        reset = 1;
        step(0, 0, 0, 0, 1, 0);
        reset = 0;
        expect_out("reset_cd", int'(MENU), 0, 0, 3, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
